// File: rtl/seek_controller.sv
`default_nettype none
// ============================================================================
// seek_controller : home/seek sequencer producing timed active-low step pulses
//                   and dir for the stepper driver. Optional macro:
//                   TR0_CHECK_EN (cross-check tr0 against cur_track in seeks).
// Revision: 1.0
// ============================================================================
module seek_controller #(
  parameter logic [15:0] STEP_LOW_CYCLES = 16'd600,
  parameter logic [15:0] STEP_GAP_CYCLES = 16'd3000,
  parameter logic [15:0] SETTLE_CYCLES   = 16'd15000,
  parameter logic [6:0]  MAX_TRACK       = 7'd79,
  parameter logic [6:0]  HOME_LIMIT      = 7'd90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_home,
  input  logic [6:0] cmd_track,
  input  logic       tr0,
  output logic       step_n,
  output logic       dir,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] cur_track,
  output logic       track_valid
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HOME    = 4'd1,
    S_DIR     = 4'd2,
    S_STEP_LO = 4'd3,
    S_STEP_HI = 4'd4,
    S_SETTLE  = 4'd5,
    S_DONE    = 4'd6,
    S_FAULT   = 4'd7
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [6:0]  r_home_cnt;
  logic [6:0]  r_target;
  logic        r_homing;
  logic        r_seek_pending;
  logic [1:0]  r_tr0_sync;
  logic        w_tr0;
  logic        w_tr0_bad;

  assign w_tr0     = r_tr0_sync[1];
  assign cmd_ready = (r_state == S_IDLE) && en;
  assign busy      = (r_state != S_IDLE);

  // Sensor is checked only once a step has fully completed, so sync lag never trips it.
`ifdef TR0_CHECK_EN
  assign w_tr0_bad = (cur_track == 7'd0) ? !w_tr0 : w_tr0;
`else
  assign w_tr0_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tr0_sync <= 2'b00;
    end else begin
      r_tr0_sync <= {r_tr0_sync[0], tr0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 16'd0;
      r_home_cnt     <= 7'd0;
      r_target       <= 7'd0;
      r_homing       <= 1'b0;
      r_seek_pending <= 1'b0;
      step_n         <= 1'b1;
      dir            <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      cur_track      <= 7'd0;
      track_valid    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if ((r_state != S_IDLE) && !en) begin
        // Aborted motion may have moved the head, so the position is forgotten.
        r_state     <= S_IDLE;
        step_n      <= 1'b1;
        track_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cmd_valid && en) begin
              r_target       <= cmd_track;
              r_home_cnt     <= 7'd0;
              r_seek_pending <= !cmd_home;
              if (!cmd_home && (cmd_track > MAX_TRACK)) begin
                err <= 1'b1;
              end else if (cmd_home || !track_valid) begin
                r_homing <= 1'b1;
                dir      <= 1'b1;
                r_state  <= S_HOME;
              end else if (cmd_track == cur_track) begin
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_homing <= 1'b0;
                dir      <= (cmd_track > cur_track) ? 1'b0 : 1'b1;
                r_state  <= S_DIR;
              end
            end
          end

          S_HOME: begin
            if (w_tr0) begin
              cur_track   <= 7'd0;
              track_valid <= 1'b1;
              r_homing    <= 1'b0;
              if (r_seek_pending && (r_target != 7'd0)) begin
                dir     <= 1'b0;
                r_state <= S_DIR;
              end else begin
                r_cnt   <= SETTLE_CYCLES - 16'd1;
                r_state <= S_SETTLE;
              end
            end else if (r_home_cnt == HOME_LIMIT) begin
              err         <= 1'b1;
              track_valid <= 1'b0;
              r_state     <= S_FAULT;
            end else begin
              dir     <= 1'b1;
              r_state <= S_DIR;
            end
          end

          S_DIR: begin
            step_n  <= 1'b0;
            r_cnt   <= STEP_LOW_CYCLES - 16'd1;
            r_state <= S_STEP_LO;
          end

          S_STEP_LO: begin
            if (r_cnt == 16'd0) begin
              step_n  <= 1'b1;
              r_cnt   <= STEP_GAP_CYCLES - 16'd1;
              r_state <= S_STEP_HI;
              if (r_homing) begin
                r_home_cnt <= r_home_cnt + 7'd1;
              end else if (!dir) begin
                if (cur_track < MAX_TRACK) cur_track <= cur_track + 7'd1;
              end else begin
                if (cur_track != 7'd0) cur_track <= cur_track - 7'd1;
              end
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end

          S_STEP_HI: begin
            if (r_cnt == 16'd0) begin
              if (r_homing) begin
                r_state <= S_HOME;
              end else if (w_tr0_bad) begin
                err         <= 1'b1;
                track_valid <= 1'b0;
                r_state     <= S_FAULT;
              end else if (cur_track == r_target) begin
                r_cnt   <= SETTLE_CYCLES - 16'd1;
                r_state <= S_SETTLE;
              end else begin
                step_n  <= 1'b0;
                r_cnt   <= STEP_LOW_CYCLES - 16'd1;
                r_state <= S_STEP_LO;
              end
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end

          S_SETTLE: begin
            if (r_cnt == 16'd0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end

          S_DONE:  r_state <= S_IDLE;
          S_FAULT: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seek_controller.sv
`default_nettype none
// tb_seek_controller : scoreboard bench for seek_controller with scaled step timing
// and a head model that raises tr0 when the physical head sits at track 0.
module tb_seek_controller;

  localparam int LO    = 12;
  localparam int GAP   = 60;
  localparam int SET   = 200;
  localparam int HLOOP = LO + GAP + 2;  // HOME + DIR + pulse per homing step
  localparam int SLOOP = LO + GAP;      // back-to-back seek steps
`ifdef TR0_CHECK_EN
  localparam int TRK_AFTER6 = 3;
`else
  localparam int TRK_AFTER6 = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_home = 1'b0;
  logic [6:0] cmd_track = 7'd0;
  logic       tr0;
  logic       cmd_ready, step_n, dir, busy, done, err, track_valid;
  logic [6:0] cur_track;

  seek_controller #(
    .STEP_LOW_CYCLES(16'(LO)),
    .STEP_GAP_CYCLES(16'(GAP)),
    .SETTLE_CYCLES  (16'(SET)),
    .MAX_TRACK      (7'd79),
    .HOME_LIMIT     (7'd90)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_home   (cmd_home),
    .cmd_track  (cmd_track),
    .tr0        (tr0),
    .step_n     (step_n),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cur_track  (cur_track),
    .track_valid(track_valid)
  );

  always #5 clk = ~clk;

  // Head model: moves one track on each rising step_n edge.
  int   head_pos = 3;
  bit   tr0_stuck0 = 1'b0;
  bit   tr0_force1 = 1'b0;
  logic prev_step_m = 1'b1;
  assign tr0 = tr0_force1 | (!tr0_stuck0 & (head_pos == 0));
  always @(posedge clk) begin
    if (rst_n && !prev_step_m && step_n)
      head_pos <= dir ? ((head_pos > 0) ? head_pos - 1 : 0) : head_pos + 1;
    prev_step_m <= step_n;
  end

  typedef struct {
    int id; bit is_err; int trk; int vld; int pulses; int lat; int dirv; int space; int acc;
  } exp_t;
  typedef struct {
    int id; int at; int sn; int bz; int tv; int rdy; int dr; int trk;
  } snap_t;

  exp_t  exp_q[$];
  snap_t snap_q[$];
  exp_t  e_cur;
  snap_t s_cur;

  int   n_total = 0, n_bad = 0, cyc = 0, to_cnt = 0, to_seen = 0;
  int   pulses = 0, base = 0, last_fall = -1, fall_cyc = 0;
  logic prev_sn = 1'b1, prev_dir = 1'b1, prev_out = 1'b0;
  bit   chk_width = 1'b1;

  task automatic chk(input string nm, input int id, input int act, input int expv);
    n_total++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s (cmd %0d): got %0d want %0d", nm, id, act, expv);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    cyc++;
    if (to_cnt != to_seen) begin
      n_total++;
      n_bad++;
      $display("FAIL wait_bound: got %0d expired waits want 0", to_cnt - to_seen);
      to_seen = to_cnt;
    end
    while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
      s_cur = snap_q.pop_front();
      if (s_cur.sn  >= 0) chk("snap_step_n",      s_cur.id, int'(step_n),      s_cur.sn);
      if (s_cur.bz  >= 0) chk("snap_busy",        s_cur.id, int'(busy),        s_cur.bz);
      if (s_cur.tv  >= 0) chk("snap_track_valid", s_cur.id, int'(track_valid), s_cur.tv);
      if (s_cur.rdy >= 0) chk("snap_cmd_ready",   s_cur.id, int'(cmd_ready),   s_cur.rdy);
      if (s_cur.dr  >= 0) chk("snap_dir",         s_cur.id, int'(dir),         s_cur.dr);
      if (s_cur.trk >= 0) chk("snap_cur_track",   s_cur.id, int'(cur_track),   s_cur.trk);
    end
    if (rst_n) begin
      if (prev_sn && !step_n) begin
        pulses++;
        if (exp_q.size() > 0) begin
          if (exp_q[0].dirv >= 0) begin
            chk("dir_at_fall", exp_q[0].id, int'(dir), exp_q[0].dirv);
            chk("dir_setup",   exp_q[0].id, int'(prev_dir), exp_q[0].dirv);
          end
          if (exp_q[0].space > 0 && last_fall >= 0)
            chk("step_spacing", exp_q[0].id, cyc - last_fall, exp_q[0].space);
        end
        last_fall = cyc;
        fall_cyc  = cyc;
      end
      if (!prev_sn && step_n && chk_width)
        chk("low_width", (exp_q.size() > 0) ? exp_q[0].id : -1, cyc - fall_cyc, LO);
      if (prev_out)
        chk("pulse_one_cycle", -1, int'(done | err), 0);
      if (done || err) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_output: got done=%0d err=%0d want none", done, err);
        end else begin
          e_cur = exp_q.pop_front();
          chk("err",         e_cur.id, int'(err),  int'(e_cur.is_err));
          chk("done",        e_cur.id, int'(done), int'(!e_cur.is_err));
          if (e_cur.trk >= 0) chk("cur_track", e_cur.id, int'(cur_track), e_cur.trk);
          chk("track_valid", e_cur.id, int'(track_valid), e_cur.vld);
          chk("pulses",      e_cur.id, pulses - base, e_cur.pulses);
          if (e_cur.lat >= 0) chk("latency", e_cur.id, cyc - e_cur.acc, e_cur.lat);
        end
        base      = pulses;
        last_fall = -1;
      end
      prev_out = done | err;
    end
    prev_sn  = step_n;
    prev_dir = dir;
  end

  task automatic issue(input bit home, input int trk, input int id, input bit is_err,
                       input int etrk, input int vld, input int np, input int lat,
                       input int dirv, input int space);
    exp_t e;
    @(negedge clk);
    #1;
    e.id = id; e.is_err = is_err; e.trk = etrk; e.vld = vld; e.pulses = np;
    e.lat = lat; e.dirv = dirv; e.space = space; e.acc = cyc;
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_home  = home;
    cmd_track = trk[6:0];
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic snap(input int id, input int dly, input int sn, input int bz, input int tv,
                      input int rdy, input int dr, input int trk);
    snap_t s;
    s.id = id; s.at = cyc + dly; s.sn = sn; s.bz = bz; s.tv = tv;
    s.rdy = rdy; s.dr = dr; s.trk = trk;
    snap_q.push_back(s);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) to_cnt++;
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    #1;
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    snap(0, 1, 1, 0, 0, 1, 1, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Home from physical track 3: three outward pulses.
    issue(1'b1, 0, 1, 1'b0, 0, 1, 3, 3*HLOOP + SET + 2, 1, HLOOP);
    wait_idle(2000);

    // Seek 5 inward, with an ignored command attempt while busy.
    issue(1'b0, 5, 2, 1'b0, 5, 1, 5, 2 + 5*SLOOP + SET, 0, SLOOP);
    repeat (20) @(negedge clk);
    #1;
    snap(2, 1, -1, 1, 1, 0, 0, -1);
    cmd_valid = 1'b1;
    cmd_home  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle(2000);

    // Seek 2 outward.
    issue(1'b0, 2, 3, 1'b0, 2, 1, 3, 2 + 3*SLOOP + SET, 1, SLOOP);
    wait_idle(2000);

    // Out-of-range seek rejected; seek to current track completes at once.
    issue(1'b0, 80, 4, 1'b1, 2, 1, 0, 1, -1, 0);
    wait_idle(50);
    issue(1'b0, 2, 5, 1'b0, 2, 1, 0, 1, -1, 0);
    wait_idle(50);

    // tr0 forced high once the head reports track 3 during a seek to 6.
`ifdef TR0_CHECK_EN
    issue(1'b0, 6, 6, 1'b1, 3, 0, 1, -1, 0, SLOOP);
`else
    issue(1'b0, 6, 6, 1'b0, 6, 1, 4, 2 + 4*SLOOP + SET, 0, SLOOP);
`endif
    n = 0;
    while (cur_track != 7'd3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) to_cnt++;
    #1;
    tr0_force1 = 1'b1;
    wait_idle(2000);
    tr0_force1 = 1'b0;

    // tr0 stuck low: homing gives up after HOME_LIMIT steps.
    tr0_stuck0 = 1'b1;
    issue(1'b1, 0, 7, 1'b1, TRK_AFTER6, 0, 90, 90*HLOOP + 2, 1, HLOOP);
    wait_idle(8000);
    snap(7, 1, 1, 0, 0, 1, 1, -1);
    repeat (2) @(negedge clk);
    #1;
    tr0_stuck0 = 1'b0;
    repeat (4) @(negedge clk);

    // Head already at track 0: home needs no pulses.
    issue(1'b1, 0, 8, 1'b0, 0, 1, 0, SET + 2, -1, 0);
    wait_idle(500);

    // Seek 6, then drop en partway through the first low pulse.
    @(negedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_home  = 1'b0;
    cmd_track = 7'd6;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (step_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) to_cnt++;
    repeat (4) @(negedge clk);
    #1;
    chk_width = 1'b0;
    en        = 1'b0;
    snap(9, 1, 1, 0, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    #1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_width = 1'b1;

    // Seek 4 with position unknown: aborted pulse + 1 homing step + 4 inward.
    issue(1'b0, 4, 10, 1'b0, 4, 1, 6, HLOOP + 3 + 4*SLOOP + SET, -1, 0);
    wait_idle(2000);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
